// File: rtl/pwm_ctrl_pkg.sv
// pwm_ctrl_pkg: shared types, level limit and clamp helper for pwm_level_ctrl.
// Rev 1.0
`default_nettype none

package pwm_ctrl_pkg;

  typedef logic [3:0] level_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    UP    = 2'd1,
    DOWN  = 2'd2,
    ESTOP = 2'd3
  } ctrl_state_e;

  localparam level_t LEVEL_MAX = 4'd9;

  function automatic level_t clamp_level(input level_t req, input level_t max_lvl);
    return (req > max_lvl) ? max_lvl : req;
  endfunction

endpackage

`default_nettype wire

// File: rtl/pwm_level_ctrl_if.sv
// pwm_level_ctrl_if: valid/ready remote level command channel from the master link.
// Rev 1.0
`default_nettype none

interface pwm_level_ctrl_if;
  import pwm_ctrl_pkg::*;

  logic   valid;
  level_t level;
  logic   ready;

  modport master (output valid, output level, input ready);
  modport slave  (input valid, input level, output ready);

endinterface

`default_nettype wire

// File: rtl/ramp_divider.sv
// ramp_divider: counts period ticks modulo DIV; tc marks the tick that wraps the count.
// Rev 1.0
`default_nettype none

module ramp_divider #(
  parameter int DIV = 4
) (
  input  wire logic clock,
  input  wire logic reset,
  input  wire logic clear,
  input  wire logic tick,
  output logic      tc
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (tick) begin
      count <= (count == LAST) ? '0 : count + 1'b1;
    end
  end

  assign tc = tick & ~clear & (count == LAST);

endmodule

`default_nettype wire

// File: rtl/pwm_level_ctrl.sv
// pwm_level_ctrl: arbitrated, soft-ramped 0..MAX_LEVEL power level for PWM_Gen with emergency stop.
// Rev 1.0 - optional remote watchdog enabled by defining PWM_CTRL_WATCHDOG_EN.
`default_nettype none

module pwm_level_ctrl
  import pwm_ctrl_pkg::*;
#(
  parameter int MAX_LEVEL  = int'(LEVEL_MAX),
  parameter int RAMP_DIV   = 4
`ifdef PWM_CTRL_WATCHDOG_EN
  ,
  parameter int WDOG_TICKS = 200
`endif
) (
  input  wire logic        clock,
  input  wire logic        reset,
  input  wire logic        period_tick,
  input  wire logic        rmt_en,
  input  wire level_t      sw_level,
  pwm_level_ctrl_if.slave  rmt,
  input  wire logic        estop,
  output level_t           pwm_level,
  output logic             busy,
  output logic             at_target,
  output logic             clamp_pulse,
  output logic             wdog_trip
);

  localparam level_t MAX_L = level_t'(MAX_LEVEL);

  ctrl_state_e state;
  ctrl_state_e next_state;
  level_t      target;
  level_t      level_next;
  level_t      sw_clamped;
  level_t      rmt_clamped;
  logic        accept;
  logic        in_stop;
  logic        ramp_clear;
  logic        step;
  logic        wdog_fire;

  assign accept      = rmt.valid & rmt.ready;
  assign in_stop     = estop | (state == ESTOP);
  assign at_target   = (pwm_level == target);
  assign sw_clamped  = clamp_level(sw_level, MAX_L);
  assign rmt_clamped = clamp_level(rmt.level, MAX_L);

  // The step divider only runs while the level is away from its target.
  assign ramp_clear = in_stop | at_target;

  ramp_divider #(
    .DIV (RAMP_DIV)
  ) u_ramp (
    .clock (clock),
    .reset (reset),
    .clear (ramp_clear),
    .tick  (period_tick),
    .tc    (step)
  );

`ifdef PWM_CTRL_WATCHDOG_EN
  logic wdog_clear;
  logic wdog_tc;

  assign wdog_clear = ~rmt_en | accept | in_stop;
  assign wdog_fire  = rmt_en & wdog_tc;

  ramp_divider #(
    .DIV (WDOG_TICKS)
  ) u_wdog (
    .clock (clock),
    .reset (reset),
    .clear (wdog_clear),
    .tick  (period_tick),
    .tc    (wdog_tc)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wdog_trip <= 1'b0;
    end else if (wdog_fire) begin
      wdog_trip <= 1'b1;
    end else if (accept && !estop) begin
      wdog_trip <= 1'b0;
    end
  end
`else
  assign wdog_fire = 1'b0;
  assign wdog_trip = 1'b0;
`endif

  always_comb begin
    level_next = pwm_level;
    if (step) begin
      level_next = (target > pwm_level) ? pwm_level + 4'd1 : pwm_level - 4'd1;
    end
  end

  // The step uses the target in force before this edge; a new target lands after it.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pwm_level   <= '0;
      target      <= '0;
      clamp_pulse <= 1'b0;
    end else if (estop) begin
      pwm_level   <= '0;
      target      <= '0;
      clamp_pulse <= 1'b0;
    end else begin
      pwm_level   <= level_next;
      clamp_pulse <= 1'b0;
      if (wdog_fire) begin
        target <= '0;
      end else if (!rmt_en) begin
        target      <= sw_clamped;
        clamp_pulse <= (sw_level > MAX_L) && (sw_clamped != target);
      end else if (accept) begin
        target      <= rmt_clamped;
        clamp_pulse <= (rmt.level > MAX_L);
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    if (estop) begin
      next_state = ESTOP;
    end else if (state == ESTOP) begin
      next_state = IDLE;
    end else if (target > level_next) begin
      next_state = UP;
    end else if (target < level_next) begin
      next_state = DOWN;
    end else begin
      next_state = IDLE;
    end
  end

  always_comb begin
    busy      = (state == UP) || (state == DOWN);
    rmt.ready = rmt_en && (state != ESTOP);
  end

endmodule

`default_nettype wire

// File: tb/tb_pwm_level_ctrl.sv
// tb_pwm_level_ctrl: directed stimulus with a cycle-level behavioural model and literal checkpoints.
// Rev 1.0
`default_nettype none

module tb_pwm_level_ctrl;

  localparam int MAXL = 9;
  localparam int RDIV = 2;
`ifdef PWM_CTRL_WATCHDOG_EN
  localparam int WDOG = 10;
`endif

  logic       clock = 1'b0;
  logic       reset;
  logic       period_tick = 1'b0;
  logic       rmt_en = 1'b0;
  logic       estop = 1'b0;
  logic [3:0] sw_level = 4'd0;
  logic [3:0] pwm_level;
  logic       busy, at_target, clamp_pulse, wdog_trip;

  pwm_level_ctrl_if rif ();

  pwm_level_ctrl #(
    .MAX_LEVEL (MAXL),
    .RAMP_DIV  (RDIV)
`ifdef PWM_CTRL_WATCHDOG_EN
    ,
    .WDOG_TICKS (WDOG)
`endif
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .period_tick (period_tick),
    .rmt_en      (rmt_en),
    .sw_level    (sw_level),
    .rmt         (rif),
    .estop       (estop),
    .pwm_level   (pwm_level),
    .busy        (busy),
    .at_target   (at_target),
    .clamp_pulse (clamp_pulse),
    .wdog_trip   (wdog_trip)
  );

  always #5 clock = ~clock;

  typedef struct {
    int level;
    int target;
    int ticks;
    int wd;
    bit stop;
    bit clamp;
    bit trip;
    bit busy;
  } mstate_t;

  mstate_t m;
  int      n_checks = 0;
  int      n_fail = 0;
  bit      checking = 1'b0;

  function automatic mstate_t model_next(mstate_t s, bit tick, bit ren, int sw,
                                         bit valid, int req, bit stop_in);
    mstate_t n = s;
    bit acc = valid && ren && !s.stop;
    bit fire = 1'b0;
    n.clamp = 1'b0;
    if (stop_in) begin
      n.level = 0; n.target = 0; n.ticks = 0; n.wd = 0;
      n.stop = 1'b1; n.busy = 1'b0;
      return n;
    end
    if (s.stop || s.level == s.target) begin
      n.ticks = 0;
    end else if (tick) begin
      n.ticks = s.ticks + 1;
      if (n.ticks == RDIV) begin
        n.ticks = 0;
        n.level = s.level + ((s.target > s.level) ? 1 : -1);
      end
    end
`ifdef PWM_CTRL_WATCHDOG_EN
    if (!ren || acc || s.stop) begin
      n.wd = 0;
    end else if (tick) begin
      n.wd = s.wd + 1;
      if (n.wd == WDOG) begin
        n.wd = 0;
        fire = 1'b1;
      end
    end
`endif
    if (fire) begin
      n.target = 0;
      n.trip = 1'b1;
    end else if (!ren) begin
      n.target = (sw > MAXL) ? MAXL : sw;
      n.clamp = (sw > MAXL) && (n.target != s.target);
    end else if (acc) begin
      n.target = (req > MAXL) ? MAXL : req;
      n.clamp = (req > MAXL);
      n.trip = 1'b0;
    end
    n.busy = !s.stop && (n.level != s.target);
    n.stop = 1'b0;
    return n;
  endfunction

  always @(posedge clock or posedge reset) begin
    if (reset) m <= '{0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0};
    else m <= model_next(m, period_tick, rmt_en, int'(sw_level), rif.valid,
                         int'(rif.level), estop);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clock) begin
    #1;
    if (checking && !reset) begin
      check("pwm_level", 32'(pwm_level), m.level);
      check("at_target", 32'(at_target), 32'(m.level == m.target));
      check("busy", 32'(busy), 32'(m.busy));
      check("clamp_pulse", 32'(clamp_pulse), 32'(m.clamp));
      check("wdog_trip", 32'(wdog_trip), 32'(m.trip));
      check("rmt_ready", 32'(rif.ready), 32'(rmt_en && !m.stop));
    end
  end

  task automatic run_periods(input int n);
    repeat (n) begin
      period_tick = 1'b0;
      repeat (2) @(negedge clock);
      period_tick = 1'b1;
      @(negedge clock);
    end
    period_tick = 1'b0;
  endtask

  task automatic cmd(input logic [3:0] lvl);
    rif.valid = 1'b1;
    rif.level = lvl;
    @(negedge clock);
    rif.valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    rif.valid = 1'b0;
    rif.level = 4'd0;
    reset = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    checking = 1'b1;
    check("rst_level", 32'(pwm_level), 0);
    check("rst_at_target", 32'(at_target), 1);
    check("rst_busy", 32'(busy), 0);
    check("rst_ready", 32'(rif.ready), 0);
    check("rst_clamp", 32'(clamp_pulse), 0);
    check("rst_wdog", 32'(wdog_trip), 0);

    // Local ramp 0 -> 5, one step every second period
    sw_level = 4'd5;
    @(negedge clock);
    run_periods(2);
    check("loc_first_step", 32'(pwm_level), 1);
    check("loc_busy", 32'(busy), 1);
    run_periods(8);
    check("loc_level5", 32'(pwm_level), 5);
    @(negedge clock);
    check("loc_idle_busy", 32'(busy), 0);
    check("loc_at_target", 32'(at_target), 1);

    // Remote over-range request clamps to 9
    rmt_en = 1'b1;
    cmd(4'd12);
    check("rmt_ready_on", 32'(rif.ready), 1);
    check("rmt_clamp_pulse", 32'(clamp_pulse), 1);
    @(negedge clock);
    check("rmt_clamp_one_cycle", 32'(clamp_pulse), 0);
    run_periods(8);
    check("rmt_level9", 32'(pwm_level), 9);

    // Reversal at 7 while heading for 9
    cmd(4'd5);
    run_periods(8);
    check("rmt_level5", 32'(pwm_level), 5);
    cmd(4'd9);
    run_periods(4);
    check("rev_at7", 32'(pwm_level), 7);
    cmd(4'd3);
    run_periods(2);
    check("rev_first_down", 32'(pwm_level), 6);
    run_periods(6);
    check("rev_level3", 32'(pwm_level), 3);
    check("rev_at_target", 32'(at_target), 1);

    // Emergency stop at level 6
    rmt_en = 1'b0;
    sw_level = 4'd6;
    @(negedge clock);
    run_periods(6);
    check("pre_estop6", 32'(pwm_level), 6);
    rmt_en = 1'b1;
    estop = 1'b1;
    rif.valid = 1'b1;
    rif.level = 4'd8;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check("estop_level0", 32'(pwm_level), 0);
      check("estop_ready0", 32'(rif.ready), 0);
    end
    estop = 1'b0;
    rif.valid = 1'b0;
    rmt_en = 1'b0;
    sw_level = 4'd2;
    @(negedge clock);
    run_periods(2);
    check("post_estop1", 32'(pwm_level), 1);
    run_periods(2);
    check("post_estop2", 32'(pwm_level), 2);

    // Switching to remote keeps the local target until a command arrives
    sw_level = 4'd4;
    @(negedge clock);
    run_periods(4);
    check("tog_level4", 32'(pwm_level), 4);
    rmt_en = 1'b1;
    run_periods(3);
    check("tog_hold4", 32'(pwm_level), 4);
    check("tog_at_target", 32'(at_target), 1);
    cmd(4'd0);
    run_periods(8);
    check("tog_level0", 32'(pwm_level), 0);

    // Remote silence: watchdog trips after 10 periods when built in
    cmd(4'd5);
    run_periods(10);
    check("wd_level5", 32'(pwm_level), 5);
`ifdef PWM_CTRL_WATCHDOG_EN
    check("wd_trip_set", 32'(wdog_trip), 1);
    run_periods(10);
    check("wd_ramped0", 32'(pwm_level), 0);
`else
    check("wd_trip_absent", 32'(wdog_trip), 0);
    run_periods(10);
    check("wd_hold5", 32'(pwm_level), 5);
`endif
    cmd(4'd3);
    check("wd_trip_cleared", 32'(wdog_trip), 0);
    run_periods(6);
    check("wd_level3", 32'(pwm_level), 3);
    @(negedge clock);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
